seg7_scan_driver: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment display driver; successor to the fixed 4-digit scan test.

---
 rtl/seg7_scan_driver_pkg.sv | 38 +++
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_scan_driver_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// segment bit positions, the blank pattern and the hex glyph table.
package seg7_scan_driver_pkg;

  localparam int PHASE_W = 4;
  typedef logic [PHASE_W-1:0] phase_t;

  // SEG bus layout, bit7..0 = a b c d e f g dp, all active-low
  localparam int SEG_DP = 0;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [6:0] glyph_t;

  // Active-low a..g patterns for 0-9, A, b, C, d, E, F
  function automatic glyph_t hex_glyph(input logic [3:0] nib);
    glyph_t g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host/display bundle for seg7_scan_driver. The master side loads the
// display word and watches the pins; the slave side is the driver itself.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load_i;
  logic [4*DIGITS-1:0]   data_i;
  logic [DIGITS-1:0]     dp_i;
  logic [DIGITS-1:0]     en_i;
  logic                  lzs_i;
  logic [3:0]            bright_i;
  logic [7:0]            seg_o;
  logic [DIGITS-1:0]     an_o;
  logic                  frame_o;

  modport master (
    output load_i, data_i, dp_i, en_i, lzs_i, bright_i,
    input  seg_o, an_o, frame_o
  );

  modport slave (
    input  load_i, data_i, dp_i, en_i, lzs_i, bright_i,
    output seg_o, an_o, frame_o
  );
endinterface

// File: rtl/seg7_scan_driver_decode.sv
// Combinational nibble -> active-low 7-segment glyph, reusable outside
// the scan driver.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nib_i,
  output glyph_t     glyph_o
);

  // Pure table lookup
  always_comb glyph_o = hex_glyph(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment scan driver: prescaler, 16-phase PWM,
// digit scan, shadowed display word with leading-zero suppression.
// SEG/AN/FRAME are registered and change only on the edge that ends a
// prescaler tick, so AN moves atomically from one digit to the next.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 3125,
  parameter int DIV_W    = 12
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  phase_t               phase_q, phase_d;
  logic [DIG_W-1:0]     dig_q, dig_d;

  logic [4*DIGITS-1:0]  data_q;
  logic [DIGITS-1:0]    dp_q, en_q;
  logic                 lzs_q;

  logic [DIGITS-1:0]    supp, lit;
  logic [3:0]           cur_nib;
  glyph_t               glyph;

  logic [7:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic                 frame_q, frame_d;

  // Prescaler wrap, phase/digit advance and frame marker
  always_comb begin
    tick    = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    phase_d = phase_q;
    dig_d   = dig_q;
    frame_d = 1'b0;
    if (tick) begin
      phase_d = phase_q + phase_t'(1);
      if (phase_q == phase_t'(15)) begin
        if (dig_q == DIG_W'(DIGITS - 1)) begin
          dig_d   = '0;
          frame_d = 1'b1;
        end else begin
          dig_d = dig_q + DIG_W'(1);
        end
      end
    end
  end

  // Leading-zero mask: a digit goes dark while it and everything above it
  // is zero, unless its own decimal point is requested; digit 0 always shows
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp     = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (data_q[4*i +: 4] == 4'h0);
      supp[i]  = lzs_q & zero_run & ~dp_q[i];
    end
    lit = en_q & ~supp;
  end

  // The digit about to be shown is the one the counters move to
  assign cur_nib = data_q[{dig_d, 2'b00} +: 4];

  seg7_decode u_decode (
    .nib_i   (cur_nib),
    .glyph_o (glyph)
  );

  // Output next-state: only refreshed on a tick, from the current shadows
  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      seg_d = SEG_BLANK;
      an_d  = '1;
      if (lit[dig_d]) begin
        seg_d         = {glyph, 1'b1};
        seg_d[SEG_DP] = ~dp_q[dig_d];
        if (phase_d <= bus.bright_i) an_d[dig_d] = 1'b0;
      end
    end
  end

  // Scan counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      phase_q <= '0;
      dig_q   <= '0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      dig_q   <= dig_d;
    end
  end

  // Shadow registers, captured on LOAD; last LOAD wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      dp_q   <= '0;
      en_q   <= '0;
      lzs_q  <= 1'b0;
    end else if (bus.load_i) begin
      data_q <= bus.data_i;
      dp_q   <= bus.dp_i;
      en_q   <= bus.en_i;
      lzs_q  <= bus.lzs_i;
    end
  end

  // Registered display pins; reset blanks the display immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign bus.seg_o   = seg_q;
  assign bus.an_o    = an_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=2:
// one PWM tick = 2 clk, one digit slot = 32 clk, one frame = 128 clk.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS   (4),
    .SCAN_DIV (2),
    .DIV_W    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0]      data;
    logic [3:0]       dp;
    logic [3:0]       en;
    logic             lzs;
    logic [3:0]       bright;
    logic [3:0][7:0]  seg_e;   // SEG seen in each digit slot, index = digit
    logic [3:0][7:0]  cnt_e;   // clk cycles AN[digit] low per frame
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.frame_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_cfg(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] en,
                          input logic lzs, input logic [3:0] bright);
    @(negedge clk);
    bus.data_i   = data;
    bus.dp_i     = dp;
    bus.en_i     = en;
    bus.lzs_i    = lzs;
    bus.bright_i = bright;
    bus.load_i   = 1'b1;
    @(negedge clk);
    bus.load_i   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt [4];
    logic [7:0] slot_seg [4];
    int multi, fr, zeros, first_n;
    logic [7:0] s31, s32, s34;
    logic [3:0] first_an;
    logic [7:0] first_seg;

    //                data      dp     en     lzs   br     seg d3..d0                         cnt d3..d0
    vecs[0] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 4'd15, {8'h9F, 8'h25, 8'h11, 8'h71}, {8'd32, 8'd32, 8'd32, 8'd32}};
    vecs[1] = '{16'h0070, 4'h0, 4'hF, 1'b1, 4'd15, {8'hFF, 8'hFF, 8'h1F, 8'h03}, {8'd0,  8'd0,  8'd32, 8'd32}};
    vecs[2] = '{16'h0070, 4'h8, 4'hF, 1'b1, 4'd15, {8'h02, 8'hFF, 8'h1F, 8'h03}, {8'd32, 8'd0,  8'd32, 8'd32}};
    vecs[3] = '{16'h3456, 4'h0, 4'hF, 1'b0, 4'd3,  {8'h0D, 8'h99, 8'h49, 8'h41}, {8'd8,  8'd8,  8'd8,  8'd8}};
    vecs[4] = '{16'h89CD, 4'h0, 4'hF, 1'b0, 4'd0,  {8'h01, 8'h09, 8'h63, 8'h85}, {8'd2,  8'd2,  8'd2,  8'd2}};
    vecs[5] = '{16'hDB0E, 4'h1, 4'h5, 1'b0, 4'd7,  {8'hFF, 8'hC1, 8'hFF, 8'h60}, {8'd0,  8'd16, 8'd0,  8'd16}};
    vecs[6] = '{16'h0000, 4'h0, 4'hF, 1'b1, 4'd15, {8'hFF, 8'hFF, 8'hFF, 8'h03}, {8'd0,  8'd0,  8'd0,  8'd32}};
    vecs[7] = '{16'h0102, 4'h2, 4'hF, 1'b1, 4'd15, {8'hFF, 8'h9F, 8'h02, 8'h25}, {8'd0,  8'd32, 8'd32, 8'd32}};

    bus.load_i   = 1'b0;
    bus.data_i   = '0;
    bus.dp_i     = '0;
    bus.en_i     = '0;
    bus.lzs_i    = 1'b0;
    bus.bright_i = 4'd15;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_seg",   32'(bus.seg_o),   32'hFF);
    check("reset_an",    32'(bus.an_o),    32'hF);
    check("reset_frame", 32'(bus.frame_o), 32'h0);
    rst = 1'b0;

    // Table: load, sync to a frame, observe one whole frame
    for (int v = 0; v < 8; v++) begin
      load_cfg(vecs[v].data, vecs[v].dp, vecs[v].en, vecs[v].lzs, vecs[v].bright);
      wait_frame(ok);
      check($sformatf("v%0d_frame_found", v), 32'(ok), 32'h1);
      for (int d = 0; d < 4; d++) begin
        cnt[d] = 0;
        slot_seg[d] = 8'h00;
      end
      multi = 0;
      fr = 0;
      for (int k = 0; k < 128; k++) begin
        if (k > 0) @(negedge clk);
        zeros = 0;
        for (int d = 0; d < 4; d++) begin
          if (bus.an_o[d] === 1'b0) begin
            cnt[d]++;
            zeros++;
          end
        end
        if (zeros > 1) multi++;
        if (k > 0 && bus.frame_o === 1'b1) fr++;
        if ((k % 32) == 31) slot_seg[k / 32] = bus.seg_o;
      end
      for (int d = 0; d < 4; d++) begin
        check($sformatf("v%0d_seg_d%0d", v, d), 32'(slot_seg[d]), 32'(vecs[v].seg_e[d]));
        check($sformatf("v%0d_an_low_d%0d", v, d), 32'(cnt[d]), 32'(vecs[v].cnt_e[d]));
      end
      check($sformatf("v%0d_an_overlap", v), 32'(multi), 32'h0);
      check($sformatf("v%0d_extra_frame", v), 32'(fr), 32'h0);
    end

    // LOAD coincident with the tick that ends digit 0's slot
    load_cfg(16'h12AF, 4'h0, 4'hF, 1'b0, 4'd15);
    wait_frame(ok);
    check("lt_frame_found", 32'(ok), 32'h1);
    s31 = 8'h00;
    s32 = 8'h00;
    s34 = 8'h00;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 31) begin
        s31 = bus.seg_o;
        bus.data_i = 16'h1235;
        bus.load_i = 1'b1;
      end
      if (k == 32) begin
        s32 = bus.seg_o;
        bus.load_i = 1'b0;
      end
      if (k == 34) s34 = bus.seg_o;
    end
    check("lt_seg_before", 32'(s31), 32'h71);
    check("lt_seg_old",    32'(s32), 32'h11);
    check("lt_seg_new",    32'(s34), 32'h0D);

    // Reset mid-scan, then reload and find the first lit digit
    repeat (37) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset_seg",   32'(bus.seg_o),   32'hFF);
    check("mid_reset_an",    32'(bus.an_o),    32'hF);
    check("mid_reset_frame", 32'(bus.frame_o), 32'h0);
    repeat (2) @(negedge clk);
    check("mid_reset_hold_an", 32'(bus.an_o), 32'hF);
    rst = 1'b0;
    bus.data_i = 16'h12AF;
    bus.load_i = 1'b1;
    first_n   = 0;
    first_an  = 4'hF;
    first_seg = 8'h00;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.load_i = 1'b0;
      if (first_n == 0 && bus.an_o !== 4'hF) begin
        first_n   = n;
        first_an  = bus.an_o;
        first_seg = bus.seg_o;
      end
    end
    check("restart_latency", 32'(first_n),   32'd2);
    check("restart_an",      32'(first_an),  32'hE);
    check("restart_seg",     32'(first_seg), 32'h71);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
